pipe_hazard_ctrl: RTL

- Pipeline control unit for the 5-stage Y86-64 core.
- Each cycle it generates the stall, bubble and set_cc controls for the F/D/E/M/W pipeline registers and the condition-code register.
- It holds the processor run/halt state machine, latches the final status and runs a stall watchdog.
- It sits beside the datapath and observes icode/stat/register IDs from the D, E, M and W stages.

---
 rtl/y86_pkg.sv | 38 +++
 rtl/haz_wdog.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the pipeline stage registers and control logic.
package y86_pkg;

    typedef enum logic [3:0] {
        HALT   = 4'h0,
        NOP    = 4'h1,
        RRMOVQ = 4'h2,
        IRMOVQ = 4'h3,
        RMMOVQ = 4'h4,
        MRMOVQ = 4'h5,
        OPQ    = 4'h6,
        JXX    = 4'h7,
        CALL   = 4'h8,
        RET    = 4'h9,
        PUSHQ  = 4'hA,
        POPQ   = 4'hB
    } icode_t;

    typedef enum logic [3:0] {
        AOK = 4'h1,
        HLT = 4'h2,
        ADR = 4'h3,
        INS = 4'h4,
        BUB = 4'h8
    } stat_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } run_state_t;

    localparam logic [3:0] RNONE = 4'hF;

    function automatic logic is_exc(input logic [3:0] s);
        return (s == HLT) || (s == ADR) || (s == INS);
    endfunction

endpackage

// File: rtl/haz_wdog.sv
// Stall watchdog: saturating count of consecutive stalled edges plus a sticky error flag.
module haz_wdog #(
    parameter int WDOG_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic wdog_err
);

    localparam logic [7:0] MAX = 8'(WDOG_MAX);

    logic [7:0] cnt;

    // The flag sets on the same edge that brings the count up to MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 8'd0;
            wdog_err <= 1'b0;
        end else begin
            if (clr) begin
                cnt <= 8'd0;
            end else if (inc && (cnt != MAX)) begin
                cnt <= cnt + 8'd1;
            end
            if (inc && (cnt >= MAX - 8'd1)) begin
                wdog_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline hazard control, run/halt FSM and stall watchdog.
// Define HAZ_PERF_CNT_EN to add the cycle/retire/load-use/mispredict counters.
module pipe_hazard_ctrl
    import y86_pkg::*;
#(
    parameter int WDOG_MAX = 16
`ifdef HAZ_PERF_CNT_EN
   ,parameter int CNT_W    = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    input  logic [3:0] m_stat,
    input  logic [3:0] W_stat,
    input  logic [3:0] W_icode,
    output logic       F_stall,
    output logic       D_stall,
    output logic       D_bubble,
    output logic       E_bubble,
    output logic       M_bubble,
    output logic       W_stall,
    output logic       set_cc,
    output logic       halted,
    output logic [3:0] proc_stat,
    output logic       wdog_err
`ifdef HAZ_PERF_CNT_EN
   ,output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt
`endif
);

    run_state_t state;
    logic       load_use;
    logic       ret_pend;
    logic       mispred;
    logic       m_exc;
    logic       w_exc;
    logic       unused_w_icode;

    assign load_use = ((E_icode == MRMOVQ) || (E_icode == POPQ)) &&
                      (E_dstM != RNONE) &&
                      ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret_pend = (D_icode == RET) || (E_icode == RET) || (M_icode == RET);
    assign mispred  = (E_icode == JXX) && !e_Cnd;
    assign m_exc    = is_exc(m_stat);
    assign w_exc    = is_exc(W_stat);

    // W_icode is observed alongside W_stat but no control depends on it.
    assign unused_w_icode = ^W_icode;

    // Reset and HALTED force a flush/freeze pattern; load-use outranks a pending RET on D.
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        if (!rst) begin
            if (state == HALTED) begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                D_bubble = 1'b0;
                W_stall  = 1'b1;
            end else begin
                F_stall  = load_use | ret_pend;
                D_stall  = load_use;
                D_bubble = mispred | (!load_use & ret_pend);
                E_bubble = mispred | load_use;
                M_bubble = m_exc | w_exc;
                W_stall  = w_exc;
                set_cc   = (E_icode == OPQ) & !m_exc & !w_exc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            halted    <= 1'b0;
            proc_stat <= AOK;
        end else if ((state == RUN) && w_exc) begin
            state     <= HALTED;
            halted    <= 1'b1;
            proc_stat <= W_stat;
        end
    end

    haz_wdog #(
        .WDOG_MAX (WDOG_MAX)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .inc      (F_stall && (state == RUN)),
        .clr      (!F_stall),
        .wdog_err (wdog_err)
    );

`ifdef HAZ_PERF_CNT_EN
    // Counters advance only while running, so the halting edge is the last one counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
            lu_cnt  <= '0;
            mp_cnt  <= '0;
        end else if (state == RUN) begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (W_stat == AOK) ret_cnt <= ret_cnt + 1'b1;
            if (load_use)      lu_cnt  <= lu_cnt + 1'b1;
            if (mispred)       mp_cnt  <= mp_cnt + 1'b1;
        end
    end
`endif

endmodule
